// File: rtl/conv1x1_sched.sv
// Sequencer for one conv1x1_engine: per output channel it loads weight/bias, streams
// every pixel of the shared feature buffer through a 2-entry skid FIFO, then drains.
`timescale 1ns/1ps
module conv1x1_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int WGT_WIDTH  = 8,
    parameter int BIAS_WIDTH = 16,
    parameter int PIX_AW     = 10,
    parameter int CH_AW      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PIX_AW-1:0]     cfg_num_pix,
    input  logic [CH_AW-1:0]      cfg_num_ch,
    output logic                  busy,
    output logic                  done,
    output logic [CH_AW-1:0]      cur_ch,
    output logic                  prm_rd,
    output logic [CH_AW-1:0]      prm_addr,
    input  logic [WGT_WIDTH-1:0]  prm_weight,
    input  logic [BIAS_WIDTH-1:0] prm_bias,
    output logic                  buf_rd,
    output logic [PIX_AW-1:0]     buf_addr,
    input  logic [DATA_WIDTH-1:0] buf_data,
    output logic                  eng_config_en,
    output logic [WGT_WIDTH-1:0]  eng_weight,
    output logic [BIAS_WIDTH-1:0] eng_bias,
    output logic [DATA_WIDTH-1:0] eng_din,
    output logic                  eng_din_valid,
    input  logic                  eng_din_ready,
    input  logic                  eng_dout_valid,
    input  logic                  eng_dout_ready,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_REQ, S_LOAD_CFG, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PIX_AW-1:0]     r_num_pix;
    logic [CH_AW-1:0]      r_num_ch;
    logic [CH_AW-1:0]      r_cur_ch;
    logic [PIX_AW:0]       r_rd_cnt;
    logic                  r_rd_pending;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_fifo_cnt;
    logic [1:0]            r_inflight;

    logic w_buf_rd, w_last_rd, w_fifo_empty, w_bypass, w_push, w_pop;
    logic w_accept, w_retire, w_drained;

    // Valid/ready: a word moves across eng_din only in a cycle where eng_din_valid and
    // eng_din_ready are both high; while valid is high and ready low, eng_din holds.
    // Credit rule: words in flight from the buffer plus words queued never exceed two.
    assign w_buf_rd     = (r_state == S_STREAM) && (r_rd_cnt <= {1'b0, r_num_pix})
                          && ((r_fifo_cnt + {1'b0, r_rd_pending}) < 2'd2);
    assign w_last_rd    = w_buf_rd && (r_rd_cnt[PIX_AW-1:0] == r_num_pix);
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);
    // Returning data goes straight to the engine when nothing is queued ahead of it.
    assign w_bypass     = w_fifo_empty && r_rd_pending && eng_din_ready;
    assign w_push       = r_rd_pending && !w_bypass;
    assign w_pop        = !w_fifo_empty && eng_din_ready;
    assign w_accept     = eng_din_valid && eng_din_ready;
    assign w_retire     = eng_dout_valid && eng_dout_ready;
    assign w_drained    = w_fifo_empty && !r_rd_pending && (r_inflight == 2'd0);

    always_comb begin
        w_next        = r_state;
        busy          = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        prm_rd        = (r_state == S_LOAD_REQ);
        eng_config_en = (r_state == S_LOAD_CFG);
        buf_rd        = w_buf_rd;
        buf_addr      = w_buf_rd ? r_rd_cnt[PIX_AW-1:0] : '0;
        eng_din_valid = !w_fifo_empty || r_rd_pending;
        eng_din       = '0;
        if (!w_fifo_empty) eng_din = r_fifo[r_rd_ptr];
        else if (r_rd_pending) eng_din = buf_data;
        case (r_state)
            S_IDLE:     if (start) w_next = S_LOAD_REQ;
            S_LOAD_REQ: w_next = S_LOAD_CFG;
            S_LOAD_CFG: w_next = S_STREAM;
            S_STREAM:   if (w_last_rd) w_next = S_DRAIN;
            S_DRAIN:    if (w_drained) w_next = (r_cur_ch == r_num_ch) ? S_DONE : S_LOAD_REQ;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    assign cur_ch     = r_cur_ch;
    assign prm_addr   = r_cur_ch;
    assign eng_weight = prm_weight;
    assign eng_bias   = prm_bias;
    assign dbg_state  = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_num_pix    <= '0;
            r_num_ch     <= '0;
            r_cur_ch     <= '0;
            r_rd_cnt     <= '0;
            r_rd_pending <= 1'b0;
            r_fifo[0]    <= '0;
            r_fifo[1]    <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_fifo_cnt   <= 2'd0;
            r_inflight   <= 2'd0;
        end else begin
            r_state      <= w_next;
            r_rd_pending <= w_buf_rd;
            if (r_state == S_IDLE && start) begin
                r_num_pix <= cfg_num_pix;
                r_num_ch  <= cfg_num_ch;
                r_cur_ch  <= '0;
            end
            if (r_state == S_DRAIN && w_drained && r_cur_ch != r_num_ch)
                r_cur_ch <= r_cur_ch + {{(CH_AW-1){1'b0}}, 1'b1};
            if (r_state == S_LOAD_CFG)
                r_rd_cnt <= '0;
            else if (w_buf_rd)
                r_rd_cnt <= r_rd_cnt + {{PIX_AW{1'b0}}, 1'b1};
            if (w_push) begin
                r_fifo[r_wr_ptr] <= buf_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            // Tracks pixels inside the engine so config never changes under them.
            case ({w_accept, w_retire})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1x1_sched.sv
// Self-checking bench for conv1x1_sched: memory and engine models, a job-level reference
// of expected reads/configs/pixels, a table of job vectors and hand-written corner sequences.
`timescale 1ns/1ps
module tb_conv1x1_sched;

    localparam int DW = 8;
    localparam int WW = 8;
    localparam int BW = 16;
    localparam int PA = 10;
    localparam int CA = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PA-1:0] cfg_num_pix = '0;
    logic [CA-1:0] cfg_num_ch = '0;
    logic          busy, done, prm_rd, buf_rd, eng_config_en, eng_din_valid;
    logic [CA-1:0] cur_ch, prm_addr;
    logic [PA-1:0] buf_addr;
    logic [WW-1:0] prm_weight = '0;
    logic [BW-1:0] prm_bias = '0;
    logic [DW-1:0] buf_data = '0;
    logic [WW-1:0] eng_weight;
    logic [BW-1:0] eng_bias;
    logic [DW-1:0] eng_din;
    logic          eng_din_ready = 1'b0;
    logic          eng_dout_valid = 1'b0;
    logic          eng_dout_ready = 1'b0;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    conv1x1_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_num_pix(cfg_num_pix), .cfg_num_ch(cfg_num_ch),
        .busy(busy), .done(done), .cur_ch(cur_ch),
        .prm_rd(prm_rd), .prm_addr(prm_addr), .prm_weight(prm_weight), .prm_bias(prm_bias),
        .buf_rd(buf_rd), .buf_addr(buf_addr), .buf_data(buf_data),
        .eng_config_en(eng_config_en), .eng_weight(eng_weight), .eng_bias(eng_bias),
        .eng_din(eng_din), .eng_din_valid(eng_din_valid), .eng_din_ready(eng_din_ready),
        .eng_dout_valid(eng_dout_valid), .eng_dout_ready(eng_dout_ready),
        .dbg_state(dbg_state)
    );

    typedef struct { int ch; logic [DW-1:0] d; } pix_t;
    typedef struct { int pix; int ch; int pct; int exp_reads; int exp_cfgs; int exp_dones; } vec_t;

    logic [DW-1:0] buf_mem [1024];
    logic [WW-1:0] prm_w [64];
    logic [BW-1:0] prm_b [64];

    logic [PA-1:0] exp_q [$];
    pix_t          exp_pix_q [$];
    int            exp_cfg_q [$];
    int            eng_q [$];

    int n_vec = 0, n_err = 0, cyc = 0, rdy_pct = 100;
    bit exp_busy = 0;
    int start_cyc = 0, last_retire = 0, loaded_ch = 0;
    int rd_cnt_job = 0, cfg_cnt_job = 0, done_cnt_job = 0, prm_cnt_job = 0;
    int first_rd_cyc = -1, last_rd_cyc = -1, first_vld_cyc = -1, first_prm_cyc = -1, first_cfg_cyc = -1;
    int rd_total = 0, acc_total = 0;
    bit rd_pend = 0, prm_pend = 0;
    logic [PA-1:0] rd_pend_addr = '0;
    int prm_pend_ch = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_din = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    task automatic accept_job();
        start_cyc = cyc;
        rd_cnt_job = 0; cfg_cnt_job = 0; done_cnt_job = 0; prm_cnt_job = 0;
        first_rd_cyc = -1; last_rd_cyc = -1; first_vld_cyc = -1;
        first_prm_cyc = -1; first_cfg_cyc = -1;
        exp_q.delete(); exp_pix_q.delete(); exp_cfg_q.delete();
        for (int c = 0; c <= int'(cfg_num_ch); c++) begin
            exp_cfg_q.push_back(c);
            for (int p = 0; p <= int'(cfg_num_pix); p++) begin
                exp_q.push_back(PA'(p));
                exp_pix_q.push_back('{c, buf_mem[p]});
            end
        end
    endtask

    // Environment: memories and engine react after each edge, DUT is observed at negedge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            buf_data   = rd_pend ? buf_mem[rd_pend_addr] : 8'($urandom);
            prm_weight = prm_pend ? prm_w[prm_pend_ch] : 8'($urandom);
            prm_bias   = prm_pend ? prm_b[prm_pend_ch] : 16'($urandom);
            rd_pend = 0;
            prm_pend = 0;
            eng_dout_valid = (eng_q.size() > 0) && (eng_q[0] <= cyc);
            eng_dout_ready = ($urandom_range(0, 99) < rdy_pct);
            eng_din_ready  = ($urandom_range(0, 99) < rdy_pct) && (eng_q.size() < 3);
            @(negedge clk);
            if (!rst_n) begin
                exp_busy = 0;
                exp_q.delete(); exp_pix_q.delete(); exp_cfg_q.delete();
                eng_q.delete();
                prev_stall = 0;
                rd_total = 0;
                acc_total = 0;
            end else begin
                bit was_busy;
                was_busy = exp_busy;
                chk("busy", 32'(busy), 32'(exp_busy));
                if (prev_stall) begin
                    chk("din_valid_hold", 32'(eng_din_valid), 32'd1);
                    chk("din_hold", 32'(eng_din), 32'(prev_din));
                end
                prev_stall = eng_din_valid && !eng_din_ready;
                prev_din = eng_din;
                if (eng_din_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
                if (buf_rd) begin
                    rd_cnt_job++;
                    rd_total++;
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                    last_rd_cyc = cyc;
                    if (exp_q.size() == 0) fail_now("extra_buf_rd");
                    else chk("buf_addr", 32'(buf_addr), 32'(exp_q.pop_front()));
                    chk("outstanding_le_2", 32'(rd_total - acc_total <= 2), 32'd1);
                    rd_pend = 1;
                    rd_pend_addr = buf_addr;
                end
                if (eng_din_valid && eng_din_ready) begin
                    pix_t p;
                    acc_total++;
                    if (exp_pix_q.size() == 0) fail_now("extra_pixel");
                    else begin
                        p = exp_pix_q.pop_front();
                        chk("pix_data", 32'(eng_din), 32'(p.d));
                        chk("pix_channel", 32'(loaded_ch), 32'(p.ch));
                    end
                    eng_q.push_back(cyc + 2);
                end
                if (eng_dout_valid && eng_dout_ready) begin
                    void'(eng_q.pop_front());
                    last_retire = cyc;
                end
                if (prm_rd) begin
                    prm_cnt_job++;
                    if (first_prm_cyc < 0) first_prm_cyc = cyc;
                    if (exp_cfg_q.size() == 0) fail_now("extra_prm_rd");
                    else begin
                        chk("prm_addr", 32'(prm_addr), 32'(exp_cfg_q[0]));
                        chk("cur_ch", 32'(cur_ch), 32'(exp_cfg_q[0]));
                    end
                    prm_pend = 1;
                    prm_pend_ch = int'(prm_addr);
                end
                if (eng_config_en) begin
                    int c;
                    cfg_cnt_job++;
                    if (first_cfg_cyc < 0) first_cfg_cyc = cyc;
                    if (exp_cfg_q.size() == 0) fail_now("extra_config");
                    else begin
                        c = exp_cfg_q.pop_front();
                        chk("cfg_weight", 32'(eng_weight), 32'(prm_w[c]));
                        chk("cfg_bias", 32'(eng_bias), 32'(prm_b[c]));
                        chk("engine_empty_at_cfg", 32'(eng_q.size()), 32'd0);
                        if (c > 0) chk("cfg_turnaround", 32'(cyc - last_retire), 32'd3);
                        loaded_ch = c;
                    end
                end
                if (done) begin
                    done_cnt_job++;
                    chk("done_after_retire", 32'(cyc - last_retire), 32'd2);
                    chk("addr_left_at_done", 32'(exp_q.size()), 32'd0);
                    chk("pix_left_at_done", 32'(exp_pix_q.size()), 32'd0);
                    chk("cfg_left_at_done", 32'(exp_cfg_q.size()), 32'd0);
                    exp_busy = 0;
                end
                if (start && !was_busy) begin
                    accept_job();
                    exp_busy = 1;
                end
            end
        end
    end

    task automatic launch(input int pix, input int ch, input int pct);
        rdy_pct = pct;
        @(posedge clk);
        #2;
        cfg_num_pix = PA'(pix);
        cfg_num_ch  = CA'(ch);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        cfg_num_pix = PA'($urandom);
        cfg_num_ch  = CA'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt_job == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({name, "_done_count"}, 32'(done_cnt_job), 32'd1);
        chk({name, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prm_rd", 32'(prm_rd), 32'd0);
        chk("rst_buf_rd", 32'(buf_rd), 32'd0);
        chk("rst_cfg_en", 32'(eng_config_en), 32'd0);
        chk("rst_din_valid", 32'(eng_din_valid), 32'd0);
        chk("rst_cur_ch", 32'(cur_ch), 32'd0);
        chk("rst_prm_addr", 32'(prm_addr), 32'd0);
        chk("rst_buf_addr", 32'(buf_addr), 32'd0);
        chk("rst_eng_din", 32'(eng_din), 32'd0);
    endtask

    task automatic check_launch_latency(input string name);
        chk({name, "_prm_lat"}, 32'(first_prm_cyc - start_cyc), 32'd1);
        chk({name, "_cfg_lat"}, 32'(first_cfg_cyc - start_cyc), 32'd2);
        chk({name, "_rd_lat"}, 32'(first_rd_cyc - start_cyc), 32'd3);
        chk({name, "_vld_lat"}, 32'(first_vld_cyc - start_cyc), 32'd4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        tbl[0] = '{3, 0, 100, 4, 1, 1};
        tbl[1] = '{7, 2, 100, 24, 3, 1};
        tbl[2] = '{15, 1, 70, 32, 2, 1};
        tbl[3] = '{0, 0, 100, 1, 1, 1};
        tbl[4] = '{0, 3, 70, 4, 4, 1};
        tbl[5] = '{5, 2, 60, 18, 3, 1};

        for (int i = 0; i < 1024; i++) buf_mem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) begin
            prm_w[i] = 8'($urandom);
            prm_b[i] = 16'($urandom);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].pix, tbl[i].ch, tbl[i].pct);
            wait_done($sformatf("vec%0d", i), 3000);
            chk($sformatf("vec%0d_reads", i), 32'(rd_cnt_job), 32'(tbl[i].exp_reads));
            chk($sformatf("vec%0d_cfgs", i), 32'(cfg_cnt_job), 32'(tbl[i].exp_cfgs));
            chk($sformatf("vec%0d_prm_rds", i), 32'(prm_cnt_job), 32'(tbl[i].exp_cfgs));
            chk($sformatf("vec%0d_dones", i), 32'(done_cnt_job), 32'(tbl[i].exp_dones));
            check_launch_latency($sformatf("vec%0d", i));
            if (tbl[i].ch == 0 && tbl[i].pct == 100)
                chk($sformatf("vec%0d_back_to_back", i), 32'(last_rd_cyc - first_rd_cyc), 32'(tbl[i].pix));
        end

        repeat (4) begin
            int pix, ch, pct;
            pix = int'($urandom_range(0, 20));
            ch  = int'($urandom_range(0, 3));
            pct = int'($urandom_range(55, 100));
            launch(pix, ch, pct);
            wait_done("rand", 4000);
            chk("rand_reads", 32'(rd_cnt_job), 32'((pix + 1) * (ch + 1)));
            chk("rand_cfgs", 32'(cfg_cnt_job), 32'(ch + 1));
        end

        // A second start while streaming must not disturb the running job.
        launch(7, 1, 80);
        for (int n = 0; n < 500 && rd_cnt_job < 3; n++) @(negedge clk);
        chk("midstart_reached_stream", 32'(rd_cnt_job >= 3), 32'd1);
        @(posedge clk);
        #2;
        cfg_num_pix = PA'(2);
        cfg_num_ch  = CA'(0);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done("midstart", 3000);
        chk("midstart_reads", 32'(rd_cnt_job), 32'd16);
        chk("midstart_cfgs", 32'(cfg_cnt_job), 32'd2);

        // Reset while streaming channel 1, then a fresh job with a new configuration.
        launch(9, 2, 80);
        for (int n = 0; n < 1000 && rd_cnt_job < 13; n++) @(negedge clk);
        chk("abort_in_ch1", 32'(cfg_cnt_job), 32'd2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        repeat (3) @(negedge clk);
        check_reset_values();
        chk("abort_no_done", 32'(done_cnt_job), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        launch(4, 1, 100);
        wait_done("after_reset", 3000);
        chk("after_reset_reads", 32'(rd_cnt_job), 32'd10);
        chk("after_reset_cfgs", 32'(cfg_cnt_job), 32'd2);
        check_launch_latency("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
